// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types, constants and sign/magnitude pre-step for the calculator display path
// Contents: state_e FSM encoding, BCD_W digit width, default W/NDIG,
//           pre_sgn/pre_mag helpers that turn a raw adder result into sign + magnitude.
package calc_pkg;

  localparam int BCD_W    = 4;
  localparam int W_DEF    = 9;
  localparam int NDIG_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  // Sign of the raw result: only a subtraction without carry-out (a borrow)
  // is negative.
  function automatic logic pre_sgn(input logic sub, input logic carry);
    return sub & ~carry;
  endfunction

  // Magnitude of the raw result, w bits wide, returned zero-extended to 32.
  // A borrow result is the two's complement of the low w-1 bits, so the
  // negation wraps modulo 2^(w-1).
  function automatic logic [31:0] pre_mag(input logic sub, input logic [31:0] bin, input int w);
    logic [31:0] lo_mask;
    logic [31:0] all_mask;
    lo_mask  = (32'd1 << (w - 1)) - 32'd1;
    all_mask = (lo_mask << 1) | 32'd1;
    if (!sub) begin
      return bin & all_mask;
    end
    if (bin[w-1]) begin
      return bin & lo_mask;
    end
    return (~bin + 32'd1) & lo_mask;
  endfunction

endpackage

// File: rtl/bcd_adj3.sv
// rtl/bcd_adj3.sv - add-3 correction for one BCD digit ahead of a double-dabble shift
// Ports: digit_i - digit before correction
//        digit_o - digit + 3 when digit_i >= 5, else digit_i (4-bit, no carry out)
module bcd_adj3
  import calc_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  output logic [BCD_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_W'(5)) begin
      digit_o = digit_i + BCD_W'(3);
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-and-add-3 converter from raw adder result to sign + BCD magnitude
// Ports: clk, rst_n (async, active-low)
//        start, sub, bin_in - conversion request, add/sub mode and raw {carry, result}
//        busy, done         - converting / one-cycle result-updated pulse
//        neg, bcd_out       - sign and BCD magnitude of the last conversion (digit 0 = ones)
module bin_to_bcd_seq
  import calc_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int NDIG = NDIG_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [W-1:0]          bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  neg,
  output logic [BCD_W*NDIG-1:0] bcd_out
);

  localparam int AW = BCD_W * NDIG;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    mag_q, mag_d, mag_pre;
  logic            sgn_q, sgn_pre;
  logic [AW-1:0]   acc_q, acc_d, acc_adj;
  logic [AW-1:0]   bcd_q;
  logic            busy_q, done_q, neg_q;

  assign sgn_pre = pre_sgn(sub, bin_in[W-1]);
  assign mag_pre = W'(pre_mag(sub, {{(32-W){1'b0}}, bin_in}, W));

  for (genvar k = 0; k < NDIG; k++) begin : g_adj
    bcd_adj3 u_adj (
      .digit_i(acc_q[BCD_W*k +: BCD_W]),
      .digit_o(acc_adj[BCD_W*k +: BCD_W])
    );
  end

  // One double-dabble iteration: corrected digits and magnitude shift left
  // as one register, the magnitude MSB entering the ones digit.
  assign acc_d = AW'({acc_adj, mag_q[W-1]});
  assign mag_d = {mag_q[W-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      sgn_q   <= 1'b0;
      acc_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mag_q   <= mag_pre;
            sgn_q   <= sgn_pre;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          acc_q <= acc_d;
          mag_q <= mag_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(W - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          // Results and done appear together; busy drops on the same edge.
          bcd_q   <= acc_q;
          neg_q   <= sgn_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign neg     = neg_q;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [8:0]  bin_in;
  logic        busy;
  logic        done;
  logic        neg;
  logic [11:0] bcd_out;

  int n_checks = 0;
  int n_fail   = 0;

  bin_to_bcd_seq #(.W(9), .NDIG(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .bin_in (bin_in),
    .busy   (busy),
    .done   (done),
    .neg    (neg),
    .bcd_out(bcd_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        sub;
    logic [8:0]  bin;
    logic [11:0] exp_bcd;
    logic        exp_neg;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Pulse start for one edge, then measure edges until done.
  task automatic run_conv(input logic s, input logic [8:0] b, output int lat);
    @(negedge clk);
    start  = 1'b1;
    sub    = s;
    bin_in = b;
    @(posedge clk);
    #1;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start  = 1'b0;
    bin_in = ~b;
    sub    = ~s;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int ndone;
    int tdone[3];
    int nd;

    rst_n  = 1'b0;
    start  = 1'b0;
    sub    = 1'b0;
    bin_in = '0;

    vecs[0]  = '{1'b0, 9'h1FF, 12'h511, 1'b0};
    vecs[1]  = '{1'b0, 9'h0FF, 12'h255, 1'b0};
    vecs[2]  = '{1'b1, 9'h105, 12'h005, 1'b0};
    vecs[3]  = '{1'b1, 9'h100, 12'h000, 1'b0};
    vecs[4]  = '{1'b1, 9'h0FB, 12'h005, 1'b1};
    vecs[5]  = '{1'b1, 9'h001, 12'h255, 1'b1};
    vecs[6]  = '{1'b0, 9'h063, 12'h099, 1'b0};
    vecs[7]  = '{1'b0, 9'h000, 12'h000, 1'b0};
    vecs[8]  = '{1'b0, 9'h0C8, 12'h200, 1'b0};
    vecs[9]  = '{1'b1, 9'h1FF, 12'h255, 1'b0};
    vecs[10] = '{1'b1, 9'h080, 12'h128, 1'b1};
    vecs[11] = '{1'b0, 9'h100, 12'h256, 1'b0};

    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_neg",  {31'd0, neg},  32'd0);
    check("reset_bcd",  {20'd0, bcd_out}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_conv(vecs[i].sub, vecs[i].bin, lat);
      check($sformatf("vec%0d_latency", i), lat, 32'd10);
      check($sformatf("vec%0d_bcd", i), {20'd0, bcd_out}, {20'd0, vecs[i].exp_bcd});
      check($sformatf("vec%0d_neg", i), {31'd0, neg}, {31'd0, vecs[i].exp_neg});
      check($sformatf("vec%0d_busy_at_done", i), {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
      check($sformatf("vec%0d_hold_bcd", i), {20'd0, bcd_out}, {20'd0, vecs[i].exp_bcd});
    end

    // Extra start pulses while busy with different data are ignored.
    @(negedge clk);
    start  = 1'b1;
    sub    = 1'b0;
    bin_in = 9'h063;
    ndone = 0;
    lat = -1;
    for (int i = 0; i <= 24; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        lat = i;
      end
      @(negedge clk);
      start  = (i == 2 || i == 4 || i == 9) ? 1'b1 : 1'b0;
      bin_in = 9'h1FF;
      sub    = 1'b1;
    end
    check("ignore_done_count", ndone, 32'd1);
    check("ignore_done_cycle", lat, 32'd10);
    check("ignore_bcd", {20'd0, bcd_out}, 32'h099);
    check("ignore_neg", {31'd0, neg}, 32'd0);

    // start held high: one result every W+2 cycles.
    @(negedge clk);
    start  = 1'b1;
    sub    = 1'b0;
    bin_in = 9'h0FF;
    nd = 0;
    for (int i = 0; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done && nd < 3) begin
        tdone[nd] = i;
        nd++;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("held_done_count", nd, 32'd3);
    if (nd == 3) begin
      check("held_first", tdone[0], 32'd10);
      check("held_period1", tdone[1] - tdone[0], 32'd11);
      check("held_period2", tdone[2] - tdone[1], 32'd11);
    end
    check("held_bcd", {20'd0, bcd_out}, 32'h255);
    repeat (15) @(posedge clk);

    // Reset in the middle of a conversion, after a nonzero negative result.
    run_conv(1'b1, 9'h001, lat);
    check("prereset_bcd", {20'd0, bcd_out}, 32'h255);
    check("prereset_neg", {31'd0, neg}, 32'd1);
    @(negedge clk);
    start  = 1'b1;
    sub    = 1'b0;
    bin_in = 9'h1FF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_neg",  {31'd0, neg},  32'd0);
    check("midreset_bcd",  {20'd0, bcd_out}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    check("midreset_no_done", ndone, 32'd0);
    check("midreset_bcd_held", {20'd0, bcd_out}, 32'd0);

    run_conv(1'b0, 9'h063, lat);
    check("postreset_latency", lat, 32'd10);
    check("postreset_bcd", {20'd0, bcd_out}, 32'h099);
    check("postreset_neg", {31'd0, neg}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
